// File: rtl/usb_tx_encoder_if.sv
// usb_tx_encoder_if: byte handshake and pad-side signals of the USB transmit bit engine
interface usb_tx_encoder_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       byte_sent;
  logic       tx_error;
  logic       busy;
  logic       dplus_out;
  logic       dminus_out;
  logic       tx_oe;
  modport master (
    output tx_start, tx_data, tx_valid, tx_last,
    input  tx_ready, byte_sent, tx_error, busy, dplus_out, dminus_out, tx_oe
  );
  modport slave (
    input  tx_start, tx_data, tx_valid, tx_last,
    output tx_ready, byte_sent, tx_error, busy, dplus_out, dminus_out, tx_oe
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB FS transmit bit engine (SYNC, LSB-first shift, NRZI, EOP); define USB_TX_STUFF_EN for bit stuffing
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LEN    = 6
) (
  input logic              clk,
  input logic              rst,
  usb_tx_encoder_if.slave  bus
);
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
  state_t        state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    sr, sr_nx;
  logic          last, last_nx;
  logic          dp, dm, dp_nx, dm_nx;
  logic          ready, sent, err;
  logic          bnd, stuff, go_stuff;
  assign bnd            = tmr == TW'(CLKS_PER_BIT - 1);
  assign bus.busy       = state != IDLE;
  assign bus.tx_oe      = state != IDLE;
  assign bus.dplus_out  = dp;
  assign bus.dminus_out = dm;
  assign bus.tx_ready   = ready & ~rst;
  assign bus.byte_sent  = sent & ~rst;
  assign bus.tx_error   = err & ~rst;
`ifdef USB_TX_STUFF_EN
  logic [2:0] ones, cnt1;
  assign cnt1     = stuff ? 3'd0 : sr[0] ? ones + 3'd1 : 3'd0;
  assign go_stuff = cnt1 == 3'(STUFF_LEN);
  // ones run length and stuff-symbol flag, advanced at every SYNC/DATA bit boundary
  always_ff @(posedge clk)
    if (rst || state == IDLE) begin
      ones  <= 3'd0;
      stuff <= 1'b0;
    end else if (bnd && (state == SYNC || state == DATA)) begin
      ones  <= cnt1;
      stuff <= go_stuff;
    end
`else
  assign stuff    = 1'b0;
  assign go_stuff = 1'b0;
`endif
  // state, bit timer, shifter and registered line symbols
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
      idx   <= 3'd0;
      sr    <= 8'd0;
      last  <= 1'b0;
      dp    <= 1'b1;
      dm    <= 1'b0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
      idx   <= idx_nx;
      sr    <= sr_nx;
      last  <= last_nx;
      dp    <= dp_nx;
      dm    <= dm_nx;
    end
  // next symbol selection: stuff toggle, next data bit, byte fetch or EOP
  always_comb begin
    state_nx = state;
    tmr_nx   = (state == IDLE || bnd) ? '0 : tmr + 1'b1;
    idx_nx   = idx;
    sr_nx    = sr;
    last_nx  = last;
    dp_nx    = dp;
    dm_nx    = dm;
    ready    = 1'b0;
    sent     = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: begin
        {dp_nx, dm_nx} = bus.tx_start ? 2'b01 : 2'b10;
        if (bus.tx_start) begin
          state_nx = SYNC;
          sr_nx    = 8'h80;
          idx_nx   = 3'd0;
          last_nx  = 1'b0;
        end
      end
      SYNC, DATA: if (bnd) begin
        sent = state == DATA && !stuff && idx == 3'd7;
        if (go_stuff)
          {dp_nx, dm_nx} = {dm, dp};
        else if (idx != 3'd7) begin
          sr_nx          = sr >> 1;
          idx_nx         = idx + 3'd1;
          {dp_nx, dm_nx} = sr[1] ? {dp, dm} : {dm, dp};
        end else if (state == DATA && last) begin
          state_nx       = EOP_SE0;
          idx_nx         = 3'd0;
          {dp_nx, dm_nx} = 2'b00;
        end else if (bus.tx_valid) begin
          ready          = 1'b1;
          state_nx       = DATA;
          sr_nx          = bus.tx_data;
          last_nx        = bus.tx_last;
          idx_nx         = 3'd0;
          {dp_nx, dm_nx} = bus.tx_data[0] ? {dp, dm} : {dm, dp};
        end else begin
          err            = 1'b1;
          state_nx       = EOP_SE0;
          idx_nx         = 3'd0;
          {dp_nx, dm_nx} = 2'b00;
        end
      end
      EOP_SE0: if (bnd) begin
        idx_nx = 3'd1;
        if (idx[0]) begin
          state_nx       = EOP_J;
          {dp_nx, dm_nx} = 2'b10;
        end
      end
      EOP_J: if (bnd) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule
